// File: rtl/spi.sv
// SPI mode-0 slave that returns a coherent {left, right} sample snapshot to the host.
// All SPI pins are oversampled by clk_48; responds to command byte 8'h01.
module spi (
    input  logic        clk_48,
    input  logic        reset,
    input  logic        SCLK,
    input  logic        CS,
    input  logic        MOSI,
    output logic        MISO,
    input  logic [15:0] left,
    input  logic [15:0] right
);

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        DATA,
        DONE
    } state_t;

    state_t      r_state;
    state_t      w_stateNext;

    logic [1:0]  r_sclkSync;
    logic [1:0]  r_csSync;
    logic [1:0]  r_mosiSync;
    logic        r_sclkPrev;

    logic [7:0]  r_cmd;
    logic [2:0]  r_bitCnt;
    logic [31:0] r_shift;
    logic [5:0]  r_dataCnt;
    logic        r_miso;

    logic        w_sclk;
    logic        w_cs;
    logic        w_mosi;
    logic        w_sclkRise;
    logic        w_sclkFall;
    logic [7:0]  w_cmdNext;
    logic        w_lastCmdBit;
    logic        w_lastDataBit;

    assign w_sclk        = r_sclkSync[1];
    assign w_cs          = r_csSync[1];
    assign w_mosi        = r_mosiSync[1];
    assign w_sclkRise    = w_sclk & ~r_sclkPrev;
    assign w_sclkFall    = ~w_sclk & r_sclkPrev;
    assign w_cmdNext     = {r_cmd[6:0], w_mosi};
    assign w_lastCmdBit  = w_sclkRise && (r_bitCnt == 3'd7);
    assign w_lastDataBit = w_sclkRise && (r_dataCnt == 6'd31);

    // CS synchroniser resets to deselected so reset release cannot look like a frame start
    always_ff @(posedge clk_48) begin
        if (reset) begin
            r_sclkSync <= 2'b00;
            r_csSync   <= 2'b11;
            r_mosiSync <= 2'b00;
            r_sclkPrev <= 1'b0;
        end else begin
            r_sclkSync <= {r_sclkSync[0], SCLK};
            r_csSync   <= {r_csSync[0], CS};
            r_mosiSync <= {r_mosiSync[0], MOSI};
            r_sclkPrev <= w_sclk;
        end
    end

    always_ff @(posedge clk_48) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        if (w_cs) begin
            w_stateNext = IDLE;
        end else begin
            case (r_state)
                IDLE: w_stateNext = CMD;
                CMD:  if (w_lastCmdBit)  w_stateNext = DATA;
                DATA: if (w_lastDataBit) w_stateNext = DONE;
                DONE: w_stateNext = DONE;
                default: w_stateNext = IDLE;
            endcase
        end
    end

    // Deselect or idle wipes everything, so an aborted frame leaves nothing behind
    always_ff @(posedge clk_48) begin
        if (reset || w_cs || r_state == IDLE) begin
            r_cmd     <= 8'h00;
            r_bitCnt  <= 3'd0;
            r_shift   <= 32'h0;
            r_dataCnt <= 6'd0;
            r_miso    <= 1'b0;
        end else begin
            case (r_state)
                CMD: begin
                    r_miso <= 1'b0;
                    if (w_sclkRise) begin
                        r_cmd    <= w_cmdNext;
                        r_bitCnt <= r_bitCnt + 3'd1;
                        if (r_bitCnt == 3'd7) begin
                            r_shift <= (w_cmdNext == 8'h01) ? {left, right} : 32'h0;
                        end
                    end
                end
                DATA: begin
                    if (w_sclkFall) begin
                        r_miso  <= r_shift[31];
                        r_shift <= {r_shift[30:0], 1'b0};
                    end
                    if (w_sclkRise) begin
                        r_dataCnt <= r_dataCnt + 6'd1;
                    end
                end
                default: begin
                    r_miso <= 1'b0;
                end
            endcase
        end
    end

    assign MISO = r_miso;

endmodule

// File: tb/tb_spi.sv
// Self-checking bench for spi: a behavioural SPI host reads frames and compares
// against the sample pair the model expects for each command.
module tb_spi;

    logic        clk_48 = 1'b0;
    logic        reset;
    logic        SCLK;
    logic        CS;
    logic        MOSI;
    logic        MISO;
    logic [15:0] left;
    logic [15:0] right;

    logic [15:0] leftSet;
    logic [15:0] rightSet;
    logic        rampEn;
    logic [15:0] rampVal = 16'h0;

    int checks = 0;
    int errors = 0;

    spi dut (
        .clk_48 (clk_48),
        .reset  (reset),
        .SCLK   (SCLK),
        .CS     (CS),
        .MOSI   (MOSI),
        .MISO   (MISO),
        .left   (left),
        .right  (right)
    );

    always #5 clk_48 = ~clk_48;

    // Constant-sum ramp: right is always the negation of left
    always @(negedge clk_48) rampVal <= rampVal + 16'd1;
    assign left  = rampEn ? rampVal : leftSet;
    assign right = rampEn ? (16'h0 - rampVal) : rightSet;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic waitClk(input int n);
        repeat (n) @(negedge clk_48);
    endtask

    // Host side of one frame: 8 SCLK half-period of 8 clocks, MISO sampled at each rise
    task automatic applyStimulus(input logic [7:0] cmd, input int nClk,
                                 output logic [63:0] rx, output logic [15:0] leftAt8);
        rx      = 64'h0;
        leftAt8 = 16'h0;
        CS      = 1'b0;
        waitClk(6);
        for (int i = 0; i < nClk; i++) begin
            MOSI = (i < 8) ? cmd[7 - i] : 1'($urandom_range(0, 1));
            waitClk(8);
            rx   = {rx[62:0], MISO};
            SCLK = 1'b1;
            if (i == 7) leftAt8 = left;
            waitClk(8);
            SCLK = 1'b0;
        end
        waitClk(6);
        CS = 1'b1;
        waitClk(4);
        checkOutput("misoCsHigh", 64'(MISO), 64'h0);
        waitClk(4);
    endtask

    // Rises 1..8 carry the command (MISO 0), 9..40 the data, anything after reads 0
    task automatic checkFrame(input string tag, input int nClk, input logic [63:0] rx,
                              input logic [31:0] expData);
        logic [31:0] gotData;
        logic [63:0] trailMask;
        gotData = 32'(rx >> (nClk - 40));
        checkOutput({tag, ".cmdPhase"}, rx >> (nClk - 8), 64'h0);
        checkOutput({tag, ".left"},  64'(gotData[31:16]), 64'(expData[31:16]));
        checkOutput({tag, ".right"}, 64'(gotData[15:0]),  64'(expData[15:0]));
        if (nClk > 40) begin
            trailMask = (64'd1 << (nClk - 40)) - 64'd1;
            checkOutput({tag, ".trailing"}, rx & trailMask, 64'h0);
        end
    endtask

    initial begin
        logic [63:0] rx;
        logic [15:0] l8;
        logic [7:0]  cmd;
        logic [15:0] diff;
        int          nClk;

        reset    = 1'b1;
        SCLK     = 1'b0;
        CS       = 1'b1;
        MOSI     = 1'b0;
        rampEn   = 1'b0;
        leftSet  = 16'h1234;
        rightSet = 16'h5678;

        for (int i = 0; i < 2; i++) begin
            SCLK = 1'b1;
            @(negedge clk_48);
            SCLK = 1'b0;
            @(negedge clk_48);
            checkOutput("resetMiso", 64'(MISO), 64'h0);
        end
        reset = 1'b0;
        waitClk(4);

        // SCLK traffic with CS high must be ignored
        for (int i = 0; i < 8; i++) begin
            MOSI = (i == 7);
            waitClk(4);
            SCLK = 1'b1;
            waitClk(4);
            checkOutput("noCsMiso", 64'(MISO), 64'h0);
            SCLK = 1'b0;
        end
        waitClk(8);

        leftSet  = 16'h0001;
        rightSet = 16'hFFFF;
        applyStimulus(8'h01, 40, rx, l8);
        checkFrame("basic", 40, rx, {16'h0001, 16'hFFFF});

        rampEn = 1'b1;
        applyStimulus(8'h01, 40, rx, l8);
        rampEn = 1'b0;
        checkFrame("rampShape", 40, rx, {rx[31:16], 16'h0 - rx[31:16]});
        diff = rx[31:16] - l8;
        checkOutput("rampWindow", 64'(diff <= 16'd6), 64'h1);

        leftSet  = 16'hA5C3;
        rightSet = 16'h3C5A;
        applyStimulus(8'h02, 40, rx, l8);
        checkFrame("cmd02", 40, rx, 32'h0);

        applyStimulus(8'h01, 4, rx, l8);
        checkOutput("abortRx", rx, 64'h0);
        leftSet  = 16'h8001;
        rightSet = 16'h7FFE;
        applyStimulus(8'h01, 40, rx, l8);
        checkFrame("afterAbort", 40, rx, {16'h8001, 16'h7FFE});

        leftSet  = 16'hBEEF;
        rightSet = 16'hCAFE;
        applyStimulus(8'h01, 48, rx, l8);
        checkFrame("long48", 48, rx, {16'hBEEF, 16'hCAFE});

        for (int f = 0; f < 10; f++) begin
            cmd      = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h01;
            nClk     = 40 + int'($urandom_range(0, 8));
            leftSet  = 16'($urandom);
            rightSet = 16'($urandom);
            applyStimulus(cmd, nClk, rx, l8);
            checkFrame("random", nClk, rx, (cmd == 8'h01) ? {leftSet, rightSet} : 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
